// File: rtl/sccb_pkg.sv
// Shared types and helpers for the SCCB write arbiter.
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Cycles allowed for the master to drop ready after a start pulse.
  localparam int BUSY_WAIT_DEFAULT = 16;

  // Number of clock cycles in TIMEOUT_US microseconds.
  function automatic int calc_to_cyc(input int clk_f, input int timeout_us);
    return (clk_f / 1_000_000) * timeout_us;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request after 'last', wrapping.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int pos;

  // Scan last+1, last+2, ... modulo N and take the first pending request.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(last) + k;
      if (pos >= N) pos = pos - N;
      if (!valid && req[pos[IW-1:0]]) begin
        valid              = 1'b1;
        gnt[pos[IW-1:0]]   = 1'b1;
        idx                = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB master among N_REQ register writers,
// with a start-acknowledge watchdog and a whole-transaction timeout.
module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int CLK_F      = 100_000_000,
  parameter int TIMEOUT_US = 1000,
  parameter int BUSY_WAIT  = BUSY_WAIT_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [8*N_REQ-1:0]   i_addr,
  input  logic [8*N_REQ-1:0]   i_data,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [N_REQ-1:0]     o_done,
  output logic [N_REQ-1:0]     o_err,
  output logic                 o_busy,
  output logic                 o_sccb_start,
  output logic [7:0]           o_sccb_addr,
  output logic [7:0]           o_sccb_data,
  input  logic                 i_sccb_ready
);

  localparam int IW     = $clog2(N_REQ);
  localparam int TO_CYC = calc_to_cyc(CLK_F, TIMEOUT_US);
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [TW-1:0] TO_LOAD  = TW'(TO_CYC);
  localparam logic [TW-1:0] BW_LOAD  = TW'(BUSY_WAIT);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  state_t            state_reg, state_next;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [IW-1:0]     win_reg, win_next;
  logic [IW-1:0]     last_reg, last_next;
  logic [7:0]        addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic              err_reg, err_next;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;

  logic [7:0] addr_arr [N_REQ];
  logic [7:0] data_arr [N_REQ];

  // Unpack the per-requester address/data slices.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = i_addr[8*gi +: 8];
    assign data_arr[gi] = i_data[8*gi +: 8];
  end

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .req   (i_req),
    .last  (last_reg),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // State, grant, latches and timer; reset returns everything to idle at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      win_reg   <= '0;
      last_reg  <= LAST_RST;
      addr_reg  <= '0;
      data_reg  <= '0;
      timer_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      win_reg   <= win_next;
      last_reg  <= last_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      timer_reg <= timer_next;
      err_reg   <= err_next;
    end
  end

  // Transaction sequencing: grant, start, wait for busy, wait for idle, report.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    win_next   = win_reg;
    last_next  = last_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    timer_next = timer_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        // Only start when the master is idle, so a start pulse is never lost.
        if (pick_valid && i_sccb_ready) begin
          gnt_next   = pick_gnt;
          win_next   = pick_idx;
          addr_next  = addr_arr[pick_idx];
          data_next  = data_arr[pick_idx];
          state_next = START;
        end
      end
      START: begin
        timer_next = BW_LOAD;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!i_sccb_ready) begin
          timer_next = TO_LOAD;
          state_next = WAIT_DONE;
        end else if (timer_reg <= TW'(1)) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      WAIT_DONE: begin
        if (i_sccb_ready) begin
          state_next = DONE;
        end else if (timer_reg <= TW'(1)) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      DONE: begin
        gnt_next   = '0;
        last_next  = win_reg;
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_gnt        = gnt_reg;
  assign o_busy       = (state_reg != IDLE);
  assign o_sccb_start = (state_reg == START);
  assign o_sccb_addr  = addr_reg;
  assign o_sccb_data  = data_reg;
  assign o_done       = (state_reg == DONE) ? gnt_reg : '0;
  assign o_err        = (state_reg == DONE && err_reg) ? gnt_reg : '0;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed self-checking bench for sccb_arbiter (2 requesters, 1 us timeout).
module tb_sccb_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data = 16'h0000;
  logic        ready = 1'b1;
  logic [1:0]  gnt, done, err;
  logic        busy, start;
  logic [7:0]  saddr, sdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sccb_arbiter #(
    .N_REQ      (2),
    .CLK_F      (100_000_000),
    .TIMEOUT_US (1),
    .BUSY_WAIT  (16)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req        (req),
    .i_addr       (addr),
    .i_data       (data),
    .o_gnt        (gnt),
    .o_done       (done),
    .o_err        (err),
    .o_busy       (busy),
    .o_sccb_start (start),
    .o_sccb_addr  (saddr),
    .o_sccb_data  (sdata),
    .i_sccb_ready (ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0; req = 2'b00; ready = 1'b1; addr = 16'h0; data = 16'h0;
    tick; tick;
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({gnt, done, err, busy, start, saddr, sdata} !== 24'h0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b done=%b err=%b busy=%b start=%b addr=%h data=%h want all 0",
               gnt, done, err, busy, start, saddr, sdata);
    end
    $display("reset: outputs gnt=%b busy=%b start=%b", gnt, busy, start);
  endtask

  task automatic test_single;
    do_reset;
    addr = 16'h0012; data = 16'h0080; req = 2'b01;
    tick;
    total++;
    if ({start, gnt} !== 3'b101) begin
      bad++; $display("FAIL single_start: got start=%b gnt=%b want start=1 gnt=01", start, gnt);
    end
    total++;
    if ({saddr, sdata} !== 16'h1280) begin
      bad++; $display("FAIL single_latch: got %h/%h want 12/80", saddr, sdata);
    end
    addr = 16'h0055; data = 16'h0066;
    tick;
    total++;
    if ({start, busy} !== 2'b01) begin
      bad++; $display("FAIL single_start_clear: got start=%b busy=%b want 0/1", start, busy);
    end
    ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      total++;
      if ({gnt, done} !== 4'b0100) begin
        bad++; $display("FAIL single_hold c%0d: got gnt=%b done=%b want 01/00", i, gnt, done);
      end
    end
    ready = 1'b1;
    tick;
    total++;
    if ({done, err, gnt} !== 6'b010001) begin
      bad++; $display("FAIL single_done: got done=%b err=%b gnt=%b want 01/00/01", done, err, gnt);
    end
    total++;
    if ({saddr, sdata} !== 16'h1280) begin
      bad++; $display("FAIL single_addr_ignored: got %h/%h want 12/80", saddr, sdata);
    end
    req = 2'b00;
    tick;
    total++;
    if ({gnt, done, busy} !== 5'b00000) begin
      bad++; $display("FAIL single_release: got gnt=%b done=%b busy=%b want 00/00/0", gnt, done, busy);
    end
    $display("single: done with addr=%h data=%h", saddr, sdata);
  endtask

  task automatic test_simultaneous;
    logic [1:0] exp_g;
    logic [7:0] exp_a, exp_d;
    do_reset;
    addr = 16'hB1A0; data = 16'hD1C0; req = 2'b11; ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_g = (g % 2 == 1) ? 2'b10 : 2'b01;
      exp_a = (g % 2 == 1) ? 8'hB1 : 8'hA0;
      exp_d = (g % 2 == 1) ? 8'hD1 : 8'hC0;
      tick;
      total++;
      if ({gnt, start} !== {exp_g, 1'b1}) begin
        bad++; $display("FAIL sim_grant%0d: got gnt=%b start=%b want %b/1", g, gnt, start, exp_g);
      end
      total++;
      if ({saddr, sdata} !== {exp_a, exp_d}) begin
        bad++; $display("FAIL sim_latch%0d: got %h/%h want %h/%h", g, saddr, sdata, exp_a, exp_d);
      end
      tick;
      ready = 1'b0;
      tick;
      ready = 1'b1;
      total++;
      if ({gnt, done} !== {exp_g, 2'b00}) begin
        bad++; $display("FAIL sim_hold%0d: got gnt=%b done=%b want %b/00", g, gnt, done, exp_g);
      end
      tick;
      total++;
      if ({done, err} !== {exp_g, 2'b00}) begin
        bad++; $display("FAIL sim_done%0d: got done=%b err=%b want %b/00", g, done, err, exp_g);
      end
      tick;
      total++;
      if ({gnt, done} !== 4'b0000) begin
        bad++; $display("FAIL sim_gap%0d: got gnt=%b done=%b want 00/00", g, gnt, done);
      end
      $display("simultaneous: transaction %0d granted %b", g, exp_g);
    end
    req = 2'b00;
    tick;
  endtask

  task automatic test_stuck_ready;
    do_reset;
    req = 2'b01; ready = 1'b1;
    tick;
    total++;
    if (gnt !== 2'b01) begin
      bad++; $display("FAIL stuck_grant: got %b want 01", gnt);
    end
    req = 2'b11;
    tick;
    for (int i = 1; i < 16; i++) begin
      tick;
      total++;
      if ({done, busy} !== 3'b001) begin
        bad++; $display("FAIL stuck_wait c%0d: got done=%b busy=%b want 00/1", i, done, busy);
      end
    end
    tick;
    total++;
    if ({done, err} !== 4'b0101) begin
      bad++; $display("FAIL stuck_err: got done=%b err=%b want 01/01", done, err);
    end
    req = 2'b10;
    tick;
    total++;
    if ({gnt, busy} !== 3'b000) begin
      bad++; $display("FAIL stuck_free: got gnt=%b busy=%b want 00/0", gnt, busy);
    end
    tick;
    total++;
    if ({gnt, start} !== 3'b101) begin
      bad++; $display("FAIL stuck_next_grant: got gnt=%b start=%b want 10/1", gnt, start);
    end
    tick;
    ready = 1'b0;
    tick;
    ready = 1'b1;
    tick;
    total++;
    if ({done, err} !== 4'b1000) begin
      bad++; $display("FAIL stuck_next_done: got done=%b err=%b want 10/00", done, err);
    end
    req = 2'b00;
    tick;
    $display("stuck_ready: watchdog error then req1 served");
  endtask

  task automatic test_hang;
    do_reset;
    req = 2'b10; ready = 1'b1;
    tick;
    total++;
    if (gnt !== 2'b10) begin
      bad++; $display("FAIL hang_grant: got %b want 10", gnt);
    end
    tick;
    ready = 1'b0;
    tick;
    for (int i = 1; i < 100; i++) begin
      tick;
      total++;
      if ({done, busy} !== 3'b001) begin
        bad++; $display("FAIL hang_wait c%0d: got done=%b busy=%b want 00/1", i, done, busy);
      end
    end
    tick;
    total++;
    if ({done, err} !== 4'b1010) begin
      bad++; $display("FAIL hang_err: got done=%b err=%b want 10/10", done, err);
    end
    req = 2'b00; ready = 1'b1;
    tick;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL hang_idle: got busy=%b want 0", busy);
    end
    $display("hang: timeout error after 100 cycles");
  endtask

  task automatic test_not_ready;
    do_reset;
    ready = 1'b0; req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if ({start, busy} !== 2'b00) begin
        bad++; $display("FAIL notready_hold c%0d: got start=%b busy=%b want 0/0", i, start, busy);
      end
    end
    ready = 1'b1;
    tick;
    total++;
    if ({start, gnt} !== 3'b101) begin
      bad++; $display("FAIL notready_start: got start=%b gnt=%b want 1/01", start, gnt);
    end
    tick;
    ready = 1'b0;
    tick;
    ready = 1'b1;
    tick;
    total++;
    if (done !== 2'b01) begin
      bad++; $display("FAIL notready_done: got %b want 01", done);
    end
    req = 2'b00;
    tick;
    $display("not_ready: start deferred until ready");
  endtask

  task automatic test_reset_mid;
    do_reset;
    req = 2'b01; ready = 1'b1;
    tick; tick;
    ready = 1'b0;
    tick; tick; tick;
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({gnt, done, err, busy, start, saddr, sdata} !== 24'h0) begin
      bad++;
      $display("FAIL midreset_outputs: got gnt=%b done=%b err=%b busy=%b start=%b addr=%h want all 0",
               gnt, done, err, busy, start, saddr);
    end
    req = 2'b11; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({done, gnt} !== 4'b0000) begin
        bad++; $display("FAIL midreset_hold c%0d: got done=%b gnt=%b want 00/00", i, done, gnt);
      end
    end
    #2 rstn = 1'b1;
    tick;
    total++;
    if ({gnt, start} !== 3'b011) begin
      bad++; $display("FAIL midreset_first: got gnt=%b start=%b want 01/1", gnt, start);
    end
    tick;
    ready = 1'b0;
    tick;
    ready = 1'b1;
    tick;
    total++;
    if (done !== 2'b01) begin
      bad++; $display("FAIL midreset_done: got %b want 01", done);
    end
    req = 2'b00;
    tick;
    $display("reset_mid: cleared and requester 0 first after release");
  endtask

  initial begin
    test_reset;
    test_single;
    test_simultaneous;
    test_stuck_ready;
    test_hang;
    test_not_ready;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
